conv_stride2_sequencer: RTL and testbench
=========================================

Name: conv_stride2_sequencer

Overview:
- Top-level sequencer for one 2D stride-2 3x3 convolution pass over an IMG_W x IMG_H feature-map buffer.
- Loads the input buffer from a streaming source, then issues window reads one kernel column per beat (three row addresses) to the MAC datapath.
- Counts accumulator results into the output buffer and signals completion.
- Sits between the input stream, the feature-map RAM, the MAC array and the output RAM.

Parameters:
IMG_W, 9, feature-map width in words
IMG_H, 16, feature-map height in rows
KERNEL, 3, kernel side (rows and columns)
STRIDE, 2, window step in both dimensions
ADDR_W, 10, address width for input and output buffers

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a pass; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE state
in_valid  in  1  input pixel available
in_ready  out  1  sequencer accepts pixel (high only in LOAD)
wr_en  out  1  input-buffer write strobe = in_valid & in_ready
wr_addr  out  ADDR_W  input-buffer write address (load counter)
rd_valid  out  1  read beat valid (high only in COMPUTE)
rd_ready  in  1  datapath accepts read beat
rd_addr1  out  ADDR_W  kernel row 0 address = base + col
rd_addr2  out  ADDR_W  rd_addr1 + IMG_W
rd_addr3  out  ADDR_W  rd_addr2 + IMG_W
rd_col  out  2  kernel column index of current beat, 0..KERNEL-1
win_first  out  1  current beat is col 0 (MAC clears accumulator)
win_last  out  1  current beat is col KERNEL-1
acc_valid  in  1  MAC reports one finished window
out_wr_en  out  1  output-buffer write strobe
out_wr_addr  out  ADDR_W  output-buffer address (result counter)

Behaviour:
- Derived constants: OUT_W=(IMG_W-KERNEL)/STRIDE+1, OUT_H=(IMG_H-KERNEL)/STRIDE+1, NWIN=OUT_W*OUT_H, NPIX=IMG_W*IMG_H. Defaults give 4, 7, 28 and 144.
- Reset (asynchronous, active-low) clears the state to IDLE and zeroes all counters. Every output is 0, including rd_addr2/3 and other derived values computed from zeroed counters. Reset asserted mid-operation aborts the pass with no done pulse.
- States are IDLE, LOAD, COMPUTE, DRAIN, DONE.
- IDLE: start=1 moves to LOAD on the next edge and clears the load, window, column and result counters. start in any other state is ignored.
- LOAD:
  - in_ready=1; wr_addr = load counter.
  - Each in_valid&in_ready increments the counter.
  - The handshake that accepts pixel NPIX-1 moves to COMPUTE on the next edge.
- COMPUTE:
  - rd_valid=1; addresses are combinational from registered window row (wr), window column (wc) and col.
  - base = wr*STRIDE*IMG_W + wc*STRIDE.
  - On rd_valid&rd_ready, col increments. After col KERNEL-1, col returns to 0 and wc increments.
  - wc wraps at OUT_W with wr incrementing.
  - When rd_valid is held without rd_ready, all read outputs hold stable.
  - The accepted beat with wr=OUT_H-1, wc=OUT_W-1, col=KERNEL-1 moves to DRAIN.
- Results: in COMPUTE or DRAIN, acc_valid with result count < NWIN gives out_wr_en=1 in the same cycle, out_wr_addr = result count, and the count increments.
  - acc_valid in IDLE, LOAD, DONE, or when count = NWIN, is ignored (out_wr_en=0).
- DRAIN: when the result count reaches NWIN (including by acc_valid in that cycle), move to DONE.
  - If the count already equals NWIN when COMPUTE exits, DRAIN still lasts one cycle.
- DONE: done=1 and busy=1 for one cycle, then IDLE. start is ignored during DONE.
- Address arithmetic is unsigned ADDR_W bits. With defaults the maximum read address is 134 (< NPIX), so no wrap occurs.
- Latency: start edge to in_ready is 1 cycle. Last pixel to rd_valid is 1 cycle. Final result to done is 1 cycle.

Test Plan:
- Nominal pass with in_valid, rd_ready and acc_valid (the last issued 2 cycles after each win_last) all held high:
  - wr_addr runs 0..143, then 84 read beats.
  - Beat 0: addrs 0/9/18, win_first=1.
  - Beat 3: addrs 2/11/20.
  - Beat 12: addrs 18/27/36.
  - Final beat: addrs 116/125/134, win_last=1.
  - out_wr_addr runs 0..27; one done pulse.
- Backpressure: in_valid toggles 1/0 during LOAD and rd_ready is low every other cycle in COMPUTE.
  - Identical address sequences; outputs stable while stalled.
  - Pass takes 288 LOAD cycles and 168 COMPUTE cycles.
- Late results: all 84 beats issued, acc_valid withheld for 10 cycles, then 28 pulses.
  - State stays DRAIN with busy=1 until pulse 28; done follows 1 cycle later.
- Spurious inputs:
  - start during LOAD/COMPUTE/DONE is ignored.
  - acc_valid during LOAD, and a 29th acc_valid, give out_wr_en=0 and do not change the count.
- Reset mid-COMPUTE at beat 40: all outputs go to 0 immediately (asynchronous), state is IDLE, no done pulse. A fresh start then repeats the nominal pass exactly.
- Back-to-back passes: start asserted in the cycle after done is accepted. The second pass restarts wr_addr and out_wr_addr from 0.

Source files
------------

// File: rtl/conv_stride2_sequencer.sv
// conv_stride2_sequencer: loads a feature map, walks stride-2 windows one kernel column per beat, counts MAC results.
module conv_stride2_sequencer #(
    parameter int IMG_W  = 9,
    parameter int IMG_H  = 16,
    parameter int KERNEL = 3,
    parameter int STRIDE = 2,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [ADDR_W-1:0] rd_addr1_o,
    output logic [ADDR_W-1:0] rd_addr2_o,
    output logic [ADDR_W-1:0] rd_addr3_o,
    output logic [1:0]        rd_col_o,
    output logic              win_first_o,
    output logic              win_last_o,
    input  logic              acc_valid_i,
    output logic              out_wr_en_o,
    output logic [ADDR_W-1:0] out_wr_addr_o
);
    localparam int OUT_W = (IMG_W - KERNEL) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - KERNEL) / STRIDE + 1;
    localparam int NWIN  = OUT_W * OUT_H;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE * IMG_W);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] load_q, wr_q, wc_q, res_q, base;
    logic [1:0]        col_q;
    logic              compute, in_hs, rd_hs, acc_ok, col_end, wc_end, last_beat;

    assign compute   = state_q == COMPUTE;
    assign in_hs     = in_valid_i && in_ready_o;
    assign rd_hs     = rd_valid_o && rd_ready_i;
    assign acc_ok    = acc_valid_i && (compute || state_q == DRAIN) && res_q < ADDR_W'(NWIN);
    assign col_end   = col_q == 2'(KERNEL - 1);
    assign wc_end    = wc_q == ADDR_W'(OUT_W - 1);
    assign last_beat = col_end && wc_end && wr_q == ADDR_W'(OUT_H - 1);
    assign base      = wr_q * ROW_STEP + wc_q * ADDR_W'(STRIDE) + ADDR_W'(col_q);

    assign busy_o        = state_q != IDLE;
    assign done_o        = state_q == DONE;
    assign in_ready_o    = state_q == LOAD;
    assign wr_en_o       = in_hs;
    assign wr_addr_o     = load_q;
    assign rd_valid_o    = compute;
    // Read-side outputs are forced to zero outside COMPUTE so idle/reset shows all-zero.
    assign rd_addr1_o    = compute ? base : '0;
    assign rd_addr2_o    = compute ? base + ADDR_W'(IMG_W) : '0;
    assign rd_addr3_o    = compute ? base + ADDR_W'(2 * IMG_W) : '0;
    assign rd_col_o      = compute ? col_q : '0;
    assign win_first_o   = compute && col_q == 2'd0;
    assign win_last_o    = compute && col_end;
    assign out_wr_en_o   = acc_ok;
    assign out_wr_addr_o = res_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            load_q  <= '0;
            wr_q    <= '0;
            wc_q    <= '0;
            col_q   <= '0;
            res_q   <= '0;
        end else begin
            if (acc_ok) res_q <= res_q + 1'b1;
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= LOAD;
                    load_q  <= '0;
                    wr_q    <= '0;
                    wc_q    <= '0;
                    col_q   <= '0;
                    res_q   <= '0;
                end
                LOAD: if (in_hs) begin
                    load_q <= load_q + 1'b1;
                    if (load_q == ADDR_W'(NPIX - 1)) state_q <= COMPUTE;
                end
                COMPUTE: if (rd_hs) begin
                    col_q <= col_end ? '0 : col_q + 1'b1;
                    if (col_end) begin
                        wc_q <= wc_end ? '0 : wc_q + 1'b1;
                        if (wc_end) wr_q <= wr_q + 1'b1;
                    end
                    if (last_beat) state_q <= DRAIN;
                end
                // Count includes a result arriving this very cycle.
                DRAIN: if (res_q == ADDR_W'(NWIN) || (acc_ok && res_q == ADDR_W'(NWIN - 1))) state_q <= DONE;
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_stride2_sequencer.sv
// tb_conv_stride2_sequencer: directed vectors, corner sequences and random traffic against a count-based reference model.
module tb_conv_stride2_sequencer;
    localparam int IMG_W  = 9;
    localparam int IMG_H  = 16;
    localparam int KERNEL = 3;
    localparam int STRIDE = 2;
    localparam int ADDR_W = 10;
    localparam int OUT_W  = (IMG_W - KERNEL) / STRIDE + 1;
    localparam int OUT_H  = (IMG_H - KERNEL) / STRIDE + 1;
    localparam int NWIN   = OUT_W * OUT_H;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NBEAT  = NWIN * KERNEL;

    logic clk = 1'b0, rst_n;
    logic start, in_valid, rd_ready, acc_valid;
    logic busy_o, done_o, in_ready_o, wr_en_o, rd_valid_o, win_first_o, win_last_o, out_wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o, rd_addr1_o, rd_addr2_o, rd_addr3_o, out_wr_addr_o;
    logic [1:0] rd_col_o;

    always #5 clk = ~clk;

    conv_stride2_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL(KERNEL), .STRIDE(STRIDE), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy_o), .done_o(done_o),
        .in_valid_i(in_valid), .in_ready_o(in_ready_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready), .rd_addr1_o(rd_addr1_o), .rd_addr2_o(rd_addr2_o),
        .rd_addr3_o(rd_addr3_o), .rd_col_o(rd_col_o), .win_first_o(win_first_o), .win_last_o(win_last_o),
        .acc_valid_i(acc_valid), .out_wr_en_o(out_wr_en_o), .out_wr_addr_o(out_wr_addr_o)
    );

    typedef struct {int beat; int a1; int a2; int a3; int first; int last;} vec_t;
    vec_t tbl[6];
    int ea1[NBEAT], ea2[NBEAT], ea3[NBEAT], ek[NBEAT];
    int cap_a1[NBEAT], cap_a2[NBEAT], cap_a3[NBEAT], cap_f[NBEAT], cap_l[NBEAT];
    int n_vec = 0, n_err = 0;
    int p_load, p_comp, p_beats, p_done, p_out;
    int iv_mode, rr_mode, acc_mode;
    logic spur, b2b, rnd_start, start_req, acc_drv, hs_last, saw_done;
    logic [1:0] pipe;

    // Phase-plus-counts model: 0 idle, 1 load, 2 compute, 3 drain, 4 done.
    int m_ph, m_pix, m_nb, m_nres;
    logic m_acc;
    assign m_acc = (m_ph == 2 || m_ph == 3) && acc_valid && m_nres < NWIN;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_pix <= 0; m_nb <= 0; m_nres <= 0;
        end else begin
            m_nres <= m_nres + (m_acc ? 1 : 0);
            case (m_ph)
                0: if (start) begin m_ph <= 1; m_pix <= 0; m_nb <= 0; m_nres <= 0; end
                1: if (in_valid) begin m_pix <= m_pix + 1; if (m_pix == NPIX - 1) m_ph <= 2; end
                2: if (rd_ready) begin m_nb <= m_nb + 1; if (m_nb == NBEAT - 1) m_ph <= 3; end
                3: if (m_nres + (m_acc ? 1 : 0) == NWIN) m_ph <= 4;
                default: m_ph <= 0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy_o, 0);           chk({tag, "_done"}, done_o, 0);
        chk({tag, "_in_ready"}, in_ready_o, 0);   chk({tag, "_wr_en"}, wr_en_o, 0);
        chk({tag, "_wr_addr"}, wr_addr_o, 0);     chk({tag, "_rd_valid"}, rd_valid_o, 0);
        chk({tag, "_rd_addr1"}, rd_addr1_o, 0);   chk({tag, "_rd_addr2"}, rd_addr2_o, 0);
        chk({tag, "_rd_addr3"}, rd_addr3_o, 0);   chk({tag, "_rd_col"}, rd_col_o, 0);
        chk({tag, "_win_first"}, win_first_o, 0); chk({tag, "_win_last"}, win_last_o, 0);
        chk({tag, "_out_wr_en"}, out_wr_en_o, 0); chk({tag, "_out_wr_addr"}, out_wr_addr_o, 0);
    endtask

    task automatic monitor();
        logic cp;
        cp = m_ph == 2 && m_nb < NBEAT;
        chk("busy", busy_o, m_ph != 0);
        chk("done", done_o, m_ph == 4);
        chk("in_ready", in_ready_o, m_ph == 1);
        chk("wr_en", wr_en_o, m_ph == 1 && in_valid);
        chk("wr_addr", wr_addr_o, m_pix);
        chk("rd_valid", rd_valid_o, m_ph == 2);
        chk("rd_addr1", rd_addr1_o, cp ? ea1[m_nb] : 0);
        chk("rd_addr2", rd_addr2_o, cp ? ea2[m_nb] : 0);
        chk("rd_addr3", rd_addr3_o, cp ? ea3[m_nb] : 0);
        chk("rd_col", rd_col_o, cp ? ek[m_nb] : 0);
        chk("win_first", win_first_o, cp && ek[m_nb] == 0);
        chk("win_last", win_last_o, cp && ek[m_nb] == KERNEL - 1);
        chk("out_wr_en", out_wr_en_o, m_acc);
        chk("out_wr_addr", out_wr_addr_o, m_nres);
        if (!busy_o && start) begin
            p_load = 0; p_comp = 0; p_beats = 0; p_done = 0; p_out = 0;
        end
        if (in_ready_o) p_load++;
        if (rd_valid_o) p_comp++;
        if (rd_valid_o && rd_ready && p_beats < NBEAT) begin
            cap_a1[p_beats] = rd_addr1_o; cap_a2[p_beats] = rd_addr2_o; cap_a3[p_beats] = rd_addr3_o;
            cap_f[p_beats] = win_first_o; cap_l[p_beats] = win_last_o;
            p_beats++;
        end
        if (done_o) p_done++;
        if (out_wr_en_o) p_out++;
        hs_last = rd_valid_o && rd_ready && win_last_o;
        saw_done = done_o;
    endtask

    task automatic drive();
        in_valid = iv_mode == 1 || (iv_mode == 2 && p_load % 2 == 1) || (iv_mode == 3 && $urandom % 2 == 1);
        rd_ready = rr_mode == 1 || (rr_mode == 2 && p_comp % 2 == 1) || (rr_mode == 3 && $urandom % 2 == 1);
        pipe = {pipe[0], hs_last};
        acc_valid = acc_mode == 0 ? acc_drv : acc_mode == 1 ? (pipe[1] | (spur & in_ready_o)) : ($urandom % 3 == 0);
        start = start_req | (spur & (in_ready_o | rd_valid_o | done_o)) | (b2b & saw_done) | (rnd_start & ($urandom % 16 == 0));
        start_req = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic start_pass();
        start_req = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic run_to_done(input string nm, input int limit);
        int k = 0;
        while (p_done == 0 && k < limit) begin cyc(); k++; end
        chk(nm, p_done, 1);
    endtask

    task automatic check_pass(input string tag, input int load_cyc, input int comp_cyc);
        chk({tag, "_load_cycles"}, p_load, load_cyc);
        chk({tag, "_compute_cycles"}, p_comp, comp_cyc);
        chk({tag, "_beats"}, p_beats, NBEAT);
        chk({tag, "_results"}, p_out, NWIN);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_b%0d_a1", tag, tbl[i].beat), cap_a1[tbl[i].beat], tbl[i].a1);
            chk($sformatf("%s_b%0d_a2", tag, tbl[i].beat), cap_a2[tbl[i].beat], tbl[i].a2);
            chk($sformatf("%s_b%0d_a3", tag, tbl[i].beat), cap_a3[tbl[i].beat], tbl[i].a3);
            chk($sformatf("%s_b%0d_first", tag, tbl[i].beat), cap_f[tbl[i].beat], tbl[i].first);
            chk($sformatf("%s_b%0d_last", tag, tbl[i].beat), cap_l[tbl[i].beat], tbl[i].last);
        end
    endtask

    initial begin
        // Expected beats from pixel coordinates of each window's kernel column.
        for (int r = 0; r < OUT_H; r++)
            for (int c = 0; c < OUT_W; c++)
                for (int k = 0; k < KERNEL; k++) begin
                    int idx;
                    idx = (r * OUT_W + c) * KERNEL + k;
                    ea1[idx] = (r * STRIDE + 0) * IMG_W + c * STRIDE + k;
                    ea2[idx] = (r * STRIDE + 1) * IMG_W + c * STRIDE + k;
                    ea3[idx] = (r * STRIDE + 2) * IMG_W + c * STRIDE + k;
                    ek[idx] = k;
                end
        tbl[0] = '{0, 0, 9, 18, 1, 0};
        tbl[1] = '{1, 1, 10, 19, 0, 0};
        tbl[2] = '{2, 2, 11, 20, 0, 1};
        tbl[3] = '{3, 2, 11, 20, 1, 0};
        tbl[4] = '{12, 18, 27, 36, 1, 0};
        tbl[5] = '{83, 116, 125, 134, 0, 1};
        p_load = 0; p_comp = 0; p_beats = 0; p_done = 0; p_out = 0;
        iv_mode = 0; rr_mode = 0; acc_mode = 0;
        spur = 0; b2b = 0; rnd_start = 0; start_req = 0; acc_drv = 0; hs_last = 0; saw_done = 0; pipe = 0;
        rst_n = 0; start = 0; in_valid = 1; rd_ready = 1; acc_valid = 1;
        #3 chk_zero("reset");
        repeat (2) cyc();
        rst_n = 1;
        cyc();

        iv_mode = 1; rr_mode = 1; acc_mode = 1;
        start_pass();
        run_to_done("nominal_done", 1000);
        check_pass("nominal", NPIX, NBEAT);
        repeat (2) cyc();

        iv_mode = 2; rr_mode = 2; spur = 1;
        start_pass();
        run_to_done("bp_done", 2000);
        check_pass("bp", 2 * NPIX, 2 * NBEAT);
        repeat (2) cyc();

        iv_mode = 1; rr_mode = 1; acc_mode = 0; acc_drv = 0;
        start_pass();
        for (int k = 0; p_beats < NBEAT && k < 1000; k++) cyc();
        chk("late_beats", p_beats, NBEAT);
        repeat (10) begin
            cyc(); #3;
            chk("late_busy", busy_o, 1);
            chk("late_nodone", done_o, 0);
        end
        acc_drv = 1;
        for (int i = 0; i <= NWIN; i++) begin
            cyc(); #3;
            chk("late_done", done_o, i == NWIN);
            chk("late_out_wr_en", out_wr_en_o, i < NWIN);
            chk("late_out_addr", out_wr_addr_o, i);
        end
        acc_drv = 0;
        repeat (2) cyc();
        chk("late_idle", busy_o, 0);
        spur = 0;

        acc_mode = 1;
        start_pass();
        for (int k = 0; p_beats < 40 && k < 1000; k++) cyc();
        chk("abort_beat", p_beats, 40);
        #2 rst_n = 0;
        #1 chk_zero("abort");
        chk("abort_nodone", p_done, 0);
        repeat (2) cyc();
        rst_n = 1;
        cyc();
        start_pass();
        run_to_done("fresh_done", 1000);
        check_pass("fresh", NPIX, NBEAT);
        repeat (2) cyc();

        start_pass();
        b2b = 1;
        run_to_done("b2b_first", 1000);
        b2b = 0;
        cyc();
        chk("b2b_in_ready", in_ready_o, 1);
        chk("b2b_wr_addr", wr_addr_o, 0);
        chk("b2b_out_addr", out_wr_addr_o, 0);
        run_to_done("b2b_second", 1000);
        chk("b2b_results", p_out, NWIN);
        repeat (2) cyc();

        iv_mode = 3; rr_mode = 3; acc_mode = 2; rnd_start = 1;
        repeat (4000) cyc();
        rnd_start = 0;
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
